fpu_share_arb: RTL

- Shares one VX_fpu_fpga instance among NUM_REQS issue requesters, e.g. per-warp FPU dispatch slots.
- Arbitrates requests round-robin and allocates an in-flight slot per accepted op; the slot index is the FPU tag.
- Looks up the owner of each FPU response by its tag and routes the response back to that requester.
- Sits between the issue/dispatch stage and the FPU core; all outstanding-op bookkeeping is owned here.

---
 rtl/fpu_share_arb_if.sv | 84 ++++++++
 rtl/fpu_share_arb.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fpu_share_arb_if.sv
// Bundle of requester, FPU and response signals for fpu_share_arb.
// slave = arbiter view, master = environment (requesters + FPU) view.
`ifndef INST_FPU_BITS
`define INST_FPU_BITS 4
`endif
`ifndef INST_MOD_BITS
`define INST_MOD_BITS 3
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef FFLAGS_BITS
`define FFLAGS_BITS 5
`endif

interface fpu_share_arb_if #(
  parameter int NUM_REQS     = 4,
  parameter int REQ_TAGW     = 8,
  parameter int MAX_INFLIGHT = 8
);
  localparam int FPU_TAGW = $clog2(MAX_INFLIGHT);
  localparam int OPW      = `INST_FPU_BITS;
  localparam int FRMW     = `INST_MOD_BITS;
  localparam int DW       = `NUM_THREADS * 32;
  localparam int FFW      = `NUM_THREADS * `FFLAGS_BITS;

  logic [NUM_REQS-1:0]          req_valid;
  logic [NUM_REQS-1:0]          req_ready;
  logic [NUM_REQS*REQ_TAGW-1:0] req_tag;
  logic [NUM_REQS*OPW-1:0]      req_op_type;
  logic [NUM_REQS*FRMW-1:0]     req_frm;
  logic [NUM_REQS*3*DW-1:0]     req_data;

  logic                fpu_valid_in;
  logic                fpu_ready_in;
  logic [FPU_TAGW-1:0] fpu_tag_in;
  logic [OPW-1:0]      fpu_op_type;
  logic [FRMW-1:0]     fpu_frm;
  logic [DW-1:0]       fpu_dataa;
  logic [DW-1:0]       fpu_datab;
  logic [DW-1:0]       fpu_datac;

  logic                fpu_valid_out;
  logic                fpu_ready_out;
  logic [FPU_TAGW-1:0] fpu_tag_out;
  logic [DW-1:0]       fpu_result;
  logic                fpu_has_fflags;
  logic [FFW-1:0]      fpu_fflags;

  logic [NUM_REQS-1:0] rsp_valid;
  logic [NUM_REQS-1:0] rsp_ready;
  logic [REQ_TAGW-1:0] rsp_tag;
  logic [DW-1:0]       rsp_result;
  logic                rsp_has_fflags;
  logic [FFW-1:0]      rsp_fflags;

  modport slave (
    input  req_valid, req_tag, req_op_type, req_frm, req_data,
    output req_ready,
    output fpu_valid_in, fpu_tag_in, fpu_op_type, fpu_frm,
    output fpu_dataa, fpu_datab, fpu_datac,
    input  fpu_ready_in,
    input  fpu_valid_out, fpu_tag_out, fpu_result,
    input  fpu_has_fflags, fpu_fflags,
    output fpu_ready_out,
    output rsp_valid, rsp_tag, rsp_result,
    output rsp_has_fflags, rsp_fflags,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_tag, req_op_type, req_frm, req_data,
    input  req_ready,
    input  fpu_valid_in, fpu_tag_in, fpu_op_type, fpu_frm,
    input  fpu_dataa, fpu_datab, fpu_datac,
    output fpu_ready_in,
    output fpu_valid_out, fpu_tag_out, fpu_result,
    output fpu_has_fflags, fpu_fflags,
    input  fpu_ready_out,
    input  rsp_valid, rsp_tag, rsp_result,
    input  rsp_has_fflags, rsp_fflags,
    output rsp_ready
  );
endinterface

// File: rtl/fpu_share_arb.sv
// Round-robin sharing of one FPU among NUM_REQS requesters with tag table.
// Optional perf counters: define FPU_SHARE_ARB_PERF_EN.
`ifndef INST_FPU_BITS
`define INST_FPU_BITS 4
`endif
`ifndef INST_MOD_BITS
`define INST_MOD_BITS 3
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef FFLAGS_BITS
`define FFLAGS_BITS 5
`endif

module fpu_share_arb #(
  parameter int NUM_REQS     = 4,
  parameter int REQ_TAGW     = 8,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  fpu_share_arb_if.slave       bus
`ifdef FPU_SHARE_ARB_PERF_EN
  ,
  output logic [31:0]          perf_stall_full,
  output logic [31:0]          perf_ops
`endif
);
  localparam int FPU_TAGW = $clog2(MAX_INFLIGHT);
  localparam int OWW      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int CNTW     = $clog2(MAX_INFLIGHT + 1);
  localparam int OPW      = `INST_FPU_BITS;
  localparam int FRMW     = `INST_MOD_BITS;
  localparam int DW       = `NUM_THREADS * 32;

  logic [MAX_INFLIGHT-1:0] slot_valid_q, slot_valid_d;
  logic [OWW-1:0]          owner_q [MAX_INFLIGHT];
  logic [REQ_TAGW-1:0]     stag_q  [MAX_INFLIGHT];
  logic [OWW-1:0]          rr_q, rr_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;

  logic                gnt_any;
  logic [OWW-1:0]      gnt;
  logic                full;
  logic [FPU_TAGW-1:0] alloc;
  logic [OWW-1:0]      own;
  logic                vld_in;
  logic                rdy_out;
  logic                hs_in;
  logic                hs_out;
  logic                free_ok;

  // Round-robin grant: first valid requester at or after rr_q.
  always_comb begin
    int idx;
    gnt     = rr_q;
    gnt_any = |bus.req_valid;
    idx     = 0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % NUM_REQS;
      if (bus.req_valid[idx]) gnt = OWW'(idx);
    end
  end

  // Lowest free slot from registered state; freed slots wait a cycle.
  always_comb begin
    alloc = '0;
    for (int i = MAX_INFLIGHT - 1; i >= 0; i--) begin
      if (!slot_valid_q[i]) alloc = FPU_TAGW'(i);
    end
  end

  assign full   = (cnt_q == CNTW'(MAX_INFLIGHT));
  assign vld_in = gnt_any && !full && !reset;
  assign hs_in  = vld_in && bus.fpu_ready_in;

  // Request side: grant handshake and operand mux toward the FPU.
  always_comb begin
    bus.req_ready = '0;
    if (vld_in && bus.fpu_ready_in) bus.req_ready[gnt] = 1'b1;
    bus.fpu_valid_in = vld_in;
    bus.fpu_tag_in   = alloc;
    bus.fpu_op_type  = bus.req_op_type[int'(gnt)*OPW +: OPW];
    bus.fpu_frm      = bus.req_frm[int'(gnt)*FRMW +: FRMW];
    bus.fpu_dataa    = bus.req_data[int'(gnt)*3*DW +: DW];
    bus.fpu_datab    = bus.req_data[int'(gnt)*3*DW + DW +: DW];
    bus.fpu_datac    = bus.req_data[int'(gnt)*3*DW + 2*DW +: DW];
  end

  assign own     = owner_q[bus.fpu_tag_out];
  assign rdy_out = bus.rsp_ready[own] && !reset;
  assign hs_out  = bus.fpu_valid_out && rdy_out;
  assign free_ok = hs_out && slot_valid_q[bus.fpu_tag_out];

  // Response side: route by slot owner, restore requester tag.
  always_comb begin
    bus.rsp_valid = '0;
    if (bus.fpu_valid_out && !reset) bus.rsp_valid[own] = 1'b1;
    bus.fpu_ready_out  = rdy_out;
    bus.rsp_tag        = stag_q[bus.fpu_tag_out];
    bus.rsp_result     = bus.fpu_result;
    bus.rsp_has_fflags = bus.fpu_has_fflags;
    bus.rsp_fflags     = bus.fpu_fflags;
  end

  // Next state for slot table, pointer and occupancy.
  always_comb begin
    slot_valid_d = slot_valid_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    if (free_ok) slot_valid_d[bus.fpu_tag_out] = 1'b0;
    if (hs_in) begin
      slot_valid_d[alloc] = 1'b1;
      if (int'(gnt) == NUM_REQS - 1) rr_d = '0;
      else                           rr_d = gnt + OWW'(1);
    end
    unique case ({hs_in, free_ok})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid_q <= '0;
      rr_q         <= '0;
      cnt_q        <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
    end
  end

  // Owner/tag payload; only meaningful while the slot is valid.
  always_ff @(posedge clk) begin
    if (hs_in) begin
      owner_q[alloc] <= gnt;
      stag_q[alloc]  <= bus.req_tag[int'(gnt)*REQ_TAGW +: REQ_TAGW];
    end
  end

`ifdef FPU_SHARE_ARB_PERF_EN
  logic [31:0] stall_q, ops_q;

  // Full-stall cycles and accepted ops, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      ops_q   <= '0;
    end else begin
      if (gnt_any && full) stall_q <= stall_q + 32'd1;
      if (hs_in)           ops_q   <= ops_q + 32'd1;
    end
  end

  assign perf_stall_full = stall_q;
  assign perf_ops        = ops_q;
`endif

`ifndef SYNTHESIS
  a_rsp_slot: assert property (@(posedge clk) disable iff (reset)
    bus.fpu_valid_out |-> slot_valid_q[bus.fpu_tag_out])
    else $error("response for free slot %0d", bus.fpu_tag_out);
  a_cnt_max: assert property (@(posedge clk) disable iff (reset)
    cnt_q <= CNTW'(MAX_INFLIGHT))
    else $error("inflight count overflow");
`endif

endmodule
